// File: rtl/invert_pipe_if.sv
// Valid/ready stream bundle for invert_pipe: input beat (data + mask) and output beat.
interface invert_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/invert_pipe.sv
// Pipelined per-lane conditional inverter built from NAND-only XOR cells,
// with a behavioural shadow path compared at the output handshake.
module invert_pipe #(
    parameter int unsigned    WIDTH      = 8,
    parameter int unsigned    STAGES     = 2,
    parameter int unsigned    CNT_W      = 8,
    // Bits XORed onto the gate result as it enters stage 0; nonzero only to exercise the checker
    parameter logic [WIDTH-1:0] ERR_INJECT = '0
) (
    input  logic             clk,
    input  logic             rst,
    invert_pipe_if.slave     bus,
    input  logic             clr_err,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             busy
);

    logic [WIDTH-1:0]  w_nand_dm;
    logic [WIDTH-1:0]  w_nand_dn;
    logic [WIDTH-1:0]  w_nand_mn;
    logic [WIDTH-1:0]  w_gate;
    logic [WIDTH-1:0]  w_shadow;
    logic [STAGES-1:0] w_ready;
    logic              w_bad;

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_gate   [STAGES];
    logic [WIDTH-1:0]  r_shadow [STAGES];
    logic              r_mismatch;
    logic [CNT_W-1:0]  r_mismatch_count;

    // Four-NAND XOR per lane, plus the behavioural reference
    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        assign w_nand_dm[g] = ~(bus.in_data[g] & bus.in_mask[g]);
        assign w_nand_dn[g] = ~(bus.in_data[g] & w_nand_dm[g]);
        assign w_nand_mn[g] = ~(bus.in_mask[g] & w_nand_dm[g]);
        assign w_gate[g]    = ~(w_nand_dn[g] & w_nand_mn[g]);
        assign w_shadow[g]  = bus.in_mask[g] ? ~bus.in_data[g] : bus.in_data[g];
    end

    // Ready ripples back from the consumer so a full pipe can drain and fill together
    always_comb begin
        w_ready                  = '0;
        w_ready[STAGES-1]        = !r_valid[STAGES-1] || bus.out_ready;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            w_ready[i] = !r_valid[i] || w_ready[i+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                r_gate[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_ready[0]) begin
                r_valid[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_gate[0]   <= w_gate ^ ERR_INJECT;
                    r_shadow[0] <= w_shadow;
                end
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_gate[i]   <= r_gate[i-1];
                        r_shadow[i] <= r_shadow[i-1];
                    end
                end
            end
        end
    end

    assign w_bad = r_valid[STAGES-1] && bus.out_ready
                   && (r_gate[STAGES-1] != r_shadow[STAGES-1]);

    // A clear coinciding with a bad beat leaves that beat counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch       <= 1'b0;
            r_mismatch_count <= '0;
        end else if (clr_err) begin
            r_mismatch       <= w_bad;
            r_mismatch_count <= w_bad ? CNT_W'(1) : '0;
        end else if (w_bad) begin
            r_mismatch <= 1'b1;
            if (!(&r_mismatch_count)) begin
                r_mismatch_count <= r_mismatch_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready    = w_ready[0];
    assign bus.out_valid   = r_valid[STAGES-1];
    assign bus.out_data    = r_gate[STAGES-1];
    assign mismatch        = r_mismatch;
    assign mismatch_count  = r_mismatch_count;
    assign busy            = |r_valid;

endmodule

// File: tb/tb_invert_pipe.sv
// Directed bench for invert_pipe: reset, mask sweep, back-pressure, mid-stream reset, error checker.
module tb_invert_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_a = 1'b0, clr_e = 1'b0, clr_s = 1'b0;
    logic       mm_a, mm_e, mm_s;
    logic [7:0] cnt_a, cnt_e;
    logic [1:0] cnt_s;
    logic       busy_a, busy_e, busy_s;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    invert_pipe_if #(.WIDTH(8)) ifc_a ();
    invert_pipe_if #(.WIDTH(8)) ifc_e ();
    invert_pipe_if #(.WIDTH(8)) ifc_s ();

    invert_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .bus(ifc_a), .clr_err(clr_a),
        .mismatch(mm_a), .mismatch_count(cnt_a), .busy(busy_a));

    invert_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(8), .ERR_INJECT(8'h10)) u_err (
        .clk(clk), .rst(rst), .bus(ifc_e), .clr_err(clr_e),
        .mismatch(mm_e), .mismatch_count(cnt_e), .busy(busy_e));

    invert_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2), .ERR_INJECT(8'h01)) u_sat (
        .clk(clk), .rst(rst), .bus(ifc_s), .clr_err(clr_s),
        .mismatch(mm_s), .mismatch_count(cnt_s), .busy(busy_s));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic [7:0] m, input logic ordy);
        ifc_a.in_valid  = v;
        ifc_a.in_data   = d;
        ifc_a.in_mask   = m;
        ifc_a.out_ready = ordy;
    endtask

    task automatic drive_err(input logic v, input logic [7:0] d);
        ifc_e.in_valid = v; ifc_e.in_data = d; ifc_e.in_mask = 8'h00; ifc_e.out_ready = 1'b1;
        ifc_s.in_valid = v; ifc_s.in_data = d; ifc_s.in_mask = 8'h00; ifc_s.out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] sw_d [3] = '{8'hA5, 8'hA5, 8'hA5};
        logic [7:0] sw_m [3] = '{8'h00, 8'hFF, 8'h0F};
        logic [7:0] sw_e [3] = '{8'hA5, 8'h5A, 8'hAA};
        logic       bp_rdy [12] = '{1,1,0,0,0,1,1,1,1,1,1,1};
        logic       bp_ov  [12] = '{0,0,1,1,1,1,1,1,1,1,1,0};
        logic [7:0] bp_od  [12] = '{0,0,1,1,1,1,2,3,4,5,6,0};
        logic [7:0] nb;

        drive_a(1'b0, 8'h00, 8'h00, 1'b1);
        drive_err(1'b0, 8'h00);
        #2;
        check("rst_out_valid", 32'(ifc_a.out_valid), 32'd0);
        check("rst_out_data",  32'(ifc_a.out_data),  32'h0);
        check("rst_mismatch",  32'(mm_a),            32'd0);
        check("rst_count",     32'(cnt_a),           32'd0);
        check("rst_busy",      32'(busy_a),          32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(ifc_a.in_ready), 32'd1);

        // Mask sweep, back to back
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 3) drive_a(1'b1, sw_d[j], sw_m[j], 1'b1);
            else       drive_a(1'b0, 8'h00, 8'h00, 1'b1);
            #1;
            if (j >= 2 && j <= 4) begin
                check($sformatf("sweep_valid%0d", j), 32'(ifc_a.out_valid), 32'd1);
                check($sformatf("sweep_data%0d", j),  32'(ifc_a.out_data),  32'(sw_e[j-2]));
            end else begin
                check($sformatf("sweep_idle%0d", j), 32'(ifc_a.out_valid), 32'd0);
            end
        end
        check("sweep_mismatch", 32'(mm_a), 32'd0);
        check("sweep_busy", 32'(busy_a), 32'd0);

        // Back-pressure: out_ready low for five cycles, then drain while filling
        nb = 8'd1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive_a(nb <= 8'd6, nb, 8'h00, c >= 5);
            #1;
            check($sformatf("bp_in_ready%0d", c),  32'(ifc_a.in_ready),  32'(bp_rdy[c]));
            check($sformatf("bp_out_valid%0d", c), 32'(ifc_a.out_valid), 32'(bp_ov[c]));
            if (bp_ov[c]) check($sformatf("bp_out_data%0d", c), 32'(ifc_a.out_data), 32'(bp_od[c]));
            if (nb <= 8'd6 && bp_rdy[c]) nb = nb + 8'd1;
        end

        // Mid-stream reset with two beats held in the pipe
        @(negedge clk); drive_a(1'b1, 8'h11, 8'h00, 1'b0);
        @(negedge clk); drive_a(1'b1, 8'h22, 8'h00, 1'b0);
        @(negedge clk); drive_a(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        check("mid_full_ready", 32'(ifc_a.in_ready), 32'd0);
        check("mid_full_busy",  32'(busy_a),         32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(ifc_a.out_valid), 32'd0);
        check("mid_rst_data",  32'(ifc_a.out_data),  32'h0);
        check("mid_rst_busy",  32'(busy_a),          32'd0);
        #1;
        rst = 1'b0;
        ifc_a.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("mid_no_valid%0d", c), 32'(ifc_a.out_valid), 32'd0);
        end
        @(negedge clk); drive_a(1'b1, 8'h3C, 8'hF0, 1'b1);
        @(negedge clk); drive_a(1'b0, 8'h00, 8'h00, 1'b1); #1;
        check("mid_lat_early", 32'(ifc_a.out_valid), 32'd0);
        @(negedge clk); #1;
        check("mid_lat_valid", 32'(ifc_a.out_valid), 32'd1);
        check("mid_lat_data",  32'(ifc_a.out_data),  32'hCC);

        // Error checker: every beat of u_err/u_sat disagrees with its shadow
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            drive_err(c == 0 || c == 1 || c == 2 || c == 5 || c == 9, 8'(c));
            clr_e = (c == 7);
            #1;
            case (c)
                2: begin
                    check("err_data_e",   32'(ifc_e.out_data), 32'h10);
                    check("err_data_s",   32'(ifc_s.out_data), 32'h01);
                    check("err_pre_mm",   32'(mm_e),  32'd0);
                end
                3: check("err_cnt1", 32'(cnt_e), 32'd1);
                5: begin
                    check("err_mm3",   32'(mm_e),  32'd1);
                    check("err_cnt3",  32'(cnt_e), 32'd3);
                    check("sat_cnt3",  32'(cnt_s), 32'd3);
                end
                8: begin
                    check("clr_bad_mm",  32'(mm_e),  32'd1);
                    check("clr_bad_cnt", 32'(cnt_e), 32'd1);
                    check("sat_cnt4",    32'(cnt_s), 32'd3);
                end
                12: begin
                    check("err_cnt_after_clr", 32'(cnt_e), 32'd2);
                    check("sat_cnt5",          32'(cnt_s), 32'd3);
                    check("sat_mm",            32'(mm_s),  32'd1);
                end
                default: ;
            endcase
        end
        @(negedge clk);
        drive_err(1'b0, 8'h00);
        clr_e = 1'b1; clr_s = 1'b1;
        @(negedge clk);
        clr_e = 1'b0; clr_s = 1'b0;
        #1;
        check("clr_mm_e",  32'(mm_e),  32'd0);
        check("clr_cnt_e", 32'(cnt_e), 32'd0);
        check("clr_cnt_s", 32'(cnt_s), 32'd0);
        check("dut_mm_end", 32'(mm_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
